// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave memory: FSM state encodings and the
// default address-window constants also used by the control unit.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int         DEF_ADDRESSLENGTH = 7;
  localparam logic [6:0] DEF_BASE          = 7'h50;
  localparam int         DEF_DEPTH         = 16;

endpackage

// File: rtl/i2c_sync2.sv
// Generic two-flop synchronizer; asynchronous active-low reset clears both flops.
module i2c_sync2 (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/i2c_slave_mem.sv
// Byte-wide register memory behind the I2C slave control unit.
// Define I2C_MEM_AUTOINC_EN to advance the pointer after every access.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter int                       ADDRESSLENGTH = DEF_ADDRESSLENGTH,
  parameter logic [ADDRESSLENGTH-1:0] BASE          = ADDRESSLENGTH'(DEF_BASE),
  parameter int                       DEPTH         = DEF_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [ADDRESSLENGTH-1:0] DirectionBuffer,
  input  logic [7:0]               InputBuffer,
  input  logic                     RorW,
  input  logic                     MemoryEnable,
  input  logic                     start,
  output logic                     HaveAddress,
  output logic [7:0]               OutputBuffer
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   w_me_s;
  logic                   w_start_s;
  logic                   w_rorw_s;
  logic                   w_strobe;
  logic                   w_hit;
  logic                   w_access;
  logic                   w_we;
  logic [ADDRESSLENGTH:0] w_diff;
  logic [PW-1:0]          w_p;
  logic [PW-1:0]          w_next;

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic          r_me_d;
  logic          r_start_d;
  logic          r_have;
  logic [7:0]    r_out;
  logic [7:0]    r_mem [DEPTH];

  i2c_sync2 u_sync_me    (.Clk(Clk), .Rst_n(Rst_n), .i_d(MemoryEnable), .o_q(w_me_s));
  i2c_sync2 u_sync_start (.Clk(Clk), .Rst_n(Rst_n), .i_d(start),        .o_q(w_start_s));
  i2c_sync2 u_sync_rorw  (.Clk(Clk), .Rst_n(Rst_n), .i_d(RorW),         .o_q(w_rorw_s));

  // Extra bit on the subtraction: a set MSB is a borrow, i.e. below BASE.
  assign w_diff   = {1'b0, DirectionBuffer} - {1'b0, BASE};
  assign w_hit    = !w_diff[ADDRESSLENGTH] &&
                    (32'(w_diff[ADDRESSLENGTH-1:0]) < 32'(DEPTH));
  assign w_strobe = w_me_s && !r_me_d;

  // A falling start_s always beats a coincident strobe.
  assign w_access = w_strobe && r_have && w_start_s && (r_state != ST_IDLE);
  assign w_we     = w_access && w_rorw_s;
  assign w_p      = (r_state == ST_ARMED) ? w_diff[PW-1:0] : r_ptr;

`ifdef I2C_MEM_AUTOINC_EN
  assign w_next = w_p + PW'(1);
`else
  assign w_next = w_p;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_me_d    <= 1'b0;
      r_start_d <= 1'b0;
      r_have    <= 1'b0;
      r_out     <= 8'hFF;
    end else begin
      r_me_d    <= w_me_s;
      r_start_d <= w_start_s;
      r_have    <= w_start_s && w_hit;
      case (r_state)
        ST_IDLE: begin
          if (w_start_s && !r_start_d) r_state <= ST_ARMED;
        end
        ST_ARMED, ST_ACTIVE: begin
          if (!w_start_s) begin
            r_state <= ST_IDLE;
          end else if (w_access) begin
            r_state <= ST_ACTIVE;
            r_ptr   <= w_next;
            if (!w_rorw_s) r_out <= r_mem[w_p];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register array rather than a RAM macro so reset can clear every byte.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_we) begin
      r_mem[w_p] <= InputBuffer;
    end
  end

  assign HaveAddress  = r_have;
  assign OutputBuffer = r_out;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Self-checking bench for i2c_slave_mem (BASE=7'h50, DEPTH=16); expected read
// bytes go into a scoreboard queue and are popped after each read strobe.
module tb_i2c_slave_mem;
  import i2c_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [6:0] DirectionBuffer = 7'h00;
  logic [7:0] InputBuffer = 8'h00;
  logic       RorW = 1'b0;
  logic       MemoryEnable = 1'b0;
  logic       start = 1'b0;
  logic       HaveAddress;
  logic [7:0] OutputBuffer;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q [$];

  i2c_slave_mem #(.ADDRESSLENGTH(7), .BASE(7'h50), .DEPTH(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .DirectionBuffer(DirectionBuffer),
    .InputBuffer(InputBuffer), .RorW(RorW), .MemoryEnable(MemoryEnable),
    .start(start), .HaveAddress(HaveAddress), .OutputBuffer(OutputBuffer)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic begin_txn(input logic [6:0] addr, input logic rw);
    DirectionBuffer = addr;
    RorW = rw;
    start = 1'b1;
    tick(6);
  endtask

  task automatic end_txn();
    start = 1'b0;
    tick(6);
  endtask

  task automatic strobe(input logic [7:0] data);
    InputBuffer = data;
    MemoryEnable = 1'b1;
    tick(6);
    MemoryEnable = 1'b0;
    tick(6);
  endtask

  task automatic read_byte(input logic [7:0] expv, input string name);
    logic [7:0] e;
    exp_q.push_back(expv);
    strobe(8'h00);
    e = exp_q.pop_front();
    tests_run++;
    if (OutputBuffer !== e) begin
      tests_failed++;
      $display("FAIL %s: OutputBuffer=%h expected %h", name, OutputBuffer, e);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    tick(3);
    tests_run++;
    if (HaveAddress !== 1'b0 || OutputBuffer !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reset_outputs: HaveAddress=%b OutputBuffer=%h expected 0 ff",
               HaveAddress, OutputBuffer);
    end
    Rst_n = 1'b1;
    tick(2);
    begin_txn(7'h5A, 1'b0);
    read_byte(8'h00, "reset_read_5A");
    end_txn();
  endtask

  task automatic test_have_address();
    logic [6:0] addrs [6] = '{7'h60, 7'h4F, 7'h50, 7'h5F, 7'h7F, 7'h00};
    logic       hits  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    DirectionBuffer = 7'h52;
    start = 1'b1;
    tick(4);
    tests_run++;
    if (HaveAddress !== 1'b1) begin
      tests_failed++;
      $display("FAIL have_52: HaveAddress=%b expected 1", HaveAddress);
    end
    for (int i = 0; i < 6; i++) begin
      DirectionBuffer = addrs[i];
      tick(2);
      tests_run++;
      if (HaveAddress !== hits[i]) begin
        tests_failed++;
        $display("FAIL have_%h: HaveAddress=%b expected %b", addrs[i], HaveAddress, hits[i]);
      end
    end
    DirectionBuffer = 7'h52;
    start = 1'b0;
    tick(4);
    tests_run++;
    if (HaveAddress !== 1'b0) begin
      tests_failed++;
      $display("FAIL have_nostart: HaveAddress=%b expected 0", HaveAddress);
    end
    tick(2);
  endtask

  task automatic test_autoinc();
    begin_txn(7'h53, 1'b1);
    strobe(8'hA5);
    strobe(8'h3C);
    end_txn();
    begin_txn(7'h53, 1'b0);
`ifdef I2C_MEM_AUTOINC_EN
    read_byte(8'hA5, "autoinc_rd0");
    read_byte(8'h3C, "autoinc_rd1");
`else
    read_byte(8'h3C, "hold_rd0");
    read_byte(8'h3C, "hold_rd1");
`endif
    end_txn();
  endtask

  task automatic test_wrap();
    begin_txn(7'h5F, 1'b1);
    strobe(8'h11);
    strobe(8'h22);
    end_txn();
    begin_txn(7'h5F, 1'b0);
`ifdef I2C_MEM_AUTOINC_EN
    read_byte(8'h11, "wrap_rd15");
    read_byte(8'h22, "wrap_rd0");
`else
    read_byte(8'h22, "wrap_rd15a");
    read_byte(8'h22, "wrap_rd15b");
`endif
    end_txn();
    begin_txn(7'h50, 1'b0);
`ifdef I2C_MEM_AUTOINC_EN
    read_byte(8'h22, "wrap_direct0");
`else
    read_byte(8'h00, "wrap_direct0");
`endif
    end_txn();
  endtask

  task automatic test_start_drop();
    begin_txn(7'h54, 1'b1);
    strobe(8'h77);
    @(negedge Clk);
    start = 1'b0;
    MemoryEnable = 1'b1;
    InputBuffer = 8'hEE;
    tick(6);
    tests_run++;
    if (dut.r_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL drop_state: state=%0d expected %0d", dut.r_state, ST_IDLE);
    end
    MemoryEnable = 1'b0;
    tick(6);
    strobe(8'hEE);
    tests_run++;
    if (dut.r_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL drop_state2: state=%0d expected %0d", dut.r_state, ST_IDLE);
    end
    begin_txn(7'h54, 1'b0);
    read_byte(8'h77, "drop_rd4");
`ifdef I2C_MEM_AUTOINC_EN
    read_byte(8'h00, "drop_rd5");
`else
    read_byte(8'h77, "drop_rd4b");
`endif
    end_txn();
  endtask

  task automatic test_reset_midway();
    begin_txn(7'h50, 1'b1);
    strobe(8'h01);
    strobe(8'h02);
    Rst_n = 1'b0;
    tick(2);
    tests_run++;
    if (OutputBuffer !== 8'hFF || HaveAddress !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: OutputBuffer=%h HaveAddress=%b expected ff 0",
               OutputBuffer, HaveAddress);
    end
    Rst_n = 1'b1;
    end_txn();
    begin_txn(7'h50, 1'b0);
    for (int i = 0; i < 4; i++) read_byte(8'h00, $sformatf("midreset_rd%0d", i));
    end_txn();
    begin_txn(7'h53, 1'b0);
    read_byte(8'h00, "midreset_rd53");
    end_txn();
    begin_txn(7'h50, 1'b1);
    strobe(8'h9A);
    end_txn();
    begin_txn(7'h50, 1'b0);
    read_byte(8'h9A, "after_reset_rd50");
    end_txn();
  endtask

  task automatic test_back_to_back();
    begin_txn(7'h58, 1'b1);
    strobe(8'hC1);
    end_txn();
    begin_txn(7'h59, 1'b1);
    strobe(8'hC2);
    end_txn();
    begin_txn(7'h58, 1'b0);
    read_byte(8'hC1, "b2b_rd8");
    end_txn();
    begin_txn(7'h59, 1'b0);
    read_byte(8'hC2, "b2b_rd9");
    end_txn();
  endtask

  initial begin
    test_reset();
    test_have_address();
    test_autoinc();
    test_wrap();
    test_start_drop();
    test_reset_midway();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
